// File: rtl/lvds_ddr_rx_deser_pkg.sv
// Shared definitions for the LVDS DDR link: FSM encodings, default sync word,
// and a width helper for the counters.
package lvds_ddr_rx_deser_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } rx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hB5;

    // Smallest width (at least 1) that can hold max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/lvds_ddr_rx_deser_sync_detect.sv
// Registered sync-word compare at both bit offsets of the incoming shift register.
// Fed with the next shift-register value so the match flags line up with the register.
module lvds_ddr_rx_deser_sync_detect
    import lvds_ddr_rx_deser_pkg::*;
#(
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(DEFAULT_SYNC_WORD)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WORD_W:0]   i_sr_next,
    output logic              o_match_even,
    output logic              o_match_odd
);

    logic r_match_even;
    logic r_match_odd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_match_even <= 1'b0;
            r_match_odd  <= 1'b0;
        end else begin
            r_match_even <= (i_sr_next[WORD_W-1:0] == SYNC_WORD);
            r_match_odd  <= (i_sr_next[WORD_W:1]   == SYNC_WORD);
        end
    end

    assign o_match_even = r_match_even;
    assign o_match_odd  = r_match_odd;

endmodule

// File: rtl/lvds_ddr_rx_deser.sv
// DDR receive deserializer: hunts for the sync word at either bit offset, confirms
// alignment, then emits data words and drops lock if syncs stop arriving.
module lvds_ddr_rx_deser
    import lvds_ddr_rx_deser_pkg::*;
#(
    parameter int                WORD_W       = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD    = WORD_W'(DEFAULT_SYNC_WORD),
    parameter int                SYNC_CONFIRM = 4,
    parameter int                MAX_GAP      = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_en,
    input  logic              i_d_in_0,
    input  logic              i_d_in_1,
    output logic [WORD_W-1:0] o_data_out,
    output logic              o_data_valid,
    output logic              o_locked,
    output logic              o_align_odd,
    output logic              o_sync_seen,
    output logic              o_lock_lost
);

    localparam int PAIRS  = WORD_W / 2;
    localparam int PH_W   = cnt_width(PAIRS - 1);
    localparam int CONF_W = cnt_width(SYNC_CONFIRM);
    localparam int GAP_W  = cnt_width(MAX_GAP);

    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(PAIRS - 1);
    localparam logic [CONF_W-1:0] CONF_TARGET = CONF_W'(SYNC_CONFIRM);
    localparam logic [GAP_W-1:0]  GAP_MAX     = GAP_W'(MAX_GAP);

    rx_state_t           r_state;
    logic [WORD_W:0]     r_sr;
    logic [PH_W-1:0]     r_phase;
    logic [CONF_W-1:0]   r_conf;
    logic [GAP_W-1:0]    r_gap;
    logic [WORD_W-1:0]   r_data_out;
    logic                r_data_valid;
    logic                r_align_odd;
    logic                r_sync_seen;
    logic                r_lock_lost;

    rx_state_t           w_state_next;
    logic [WORD_W:0]     w_sr_next;
    logic [PH_W-1:0]     w_phase_next;
    logic [CONF_W-1:0]   w_conf_next;
    logic [CONF_W-1:0]   w_conf_inc;
    logic [GAP_W-1:0]    w_gap_next;
    logic [GAP_W-1:0]    w_gap_inc;
    logic [WORD_W-1:0]   w_data_next;
    logic [WORD_W-1:0]   w_word;
    logic                w_valid_next;
    logic                w_align_next;
    logic                w_sync_next;
    logic                w_lost_next;
    logic                w_match_even;
    logic                w_match_odd;
    logic                w_word_sync;
    logic                w_boundary;

    // The shift register freezes while disabled so the detector sees no new bits.
    assign w_sr_next = i_rx_en ? {r_sr[WORD_W-2:0], i_d_in_0, i_d_in_1} : r_sr;

    lvds_ddr_rx_deser_sync_detect #(
        .WORD_W    (WORD_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sr_next    (w_sr_next),
        .o_match_even (w_match_even),
        .o_match_odd  (w_match_odd)
    );

    assign w_boundary  = (r_phase == PH_LAST);
    assign w_word      = r_align_odd ? r_sr[WORD_W:1] : r_sr[WORD_W-1:0];
    assign w_word_sync = r_align_odd ? w_match_odd : w_match_even;
    assign w_conf_inc  = r_conf + 1'b1;
    assign w_gap_inc   = (r_gap == GAP_MAX) ? r_gap : r_gap + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_conf_next  = r_conf;
        w_gap_next   = r_gap;
        w_data_next  = r_data_out;
        w_align_next = r_align_odd;
        w_valid_next = 1'b0;
        w_sync_next  = 1'b0;
        w_lost_next  = 1'b0;

        if (!i_rx_en) begin
            w_state_next = ST_HUNT;
            w_phase_next = '0;
            w_conf_next  = '0;
            w_gap_next   = '0;
            w_lost_next  = (r_state == ST_LOCKED);
        end else begin
            case (r_state)
                ST_HUNT: begin
                    w_phase_next = '0;
                    // Even offset wins a tie.
                    if (w_match_even || w_match_odd) begin
                        w_align_next = !w_match_even;
                        w_conf_next  = CONF_W'(1);
                        w_gap_next   = '0;
                        w_sync_next  = 1'b1;
                        w_state_next = (SYNC_CONFIRM == 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end

                ST_CONFIRM: begin
                    w_phase_next = w_boundary ? '0 : r_phase + 1'b1;
                    if (w_boundary) begin
                        if (w_word_sync) begin
                            w_sync_next = 1'b1;
                            w_conf_next = w_conf_inc;
                            if (w_conf_inc == CONF_TARGET) begin
                                w_state_next = ST_LOCKED;
                                w_gap_next   = '0;
                            end
                        end else begin
                            w_state_next = ST_HUNT;
                            w_conf_next  = '0;
                            w_gap_next   = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    w_phase_next = w_boundary ? '0 : r_phase + 1'b1;
                    if (w_boundary) begin
                        if (w_word_sync) begin
                            w_gap_next  = '0;
                            w_sync_next = 1'b1;
                        end else if (w_gap_inc == GAP_MAX) begin
                            w_state_next = ST_HUNT;
                            w_lost_next  = 1'b1;
                            w_phase_next = '0;
                            w_conf_next  = '0;
                            w_gap_next   = '0;
                        end else begin
                            w_gap_next   = w_gap_inc;
                            w_data_next  = w_word;
                            w_valid_next = 1'b1;
                        end
                    end
                end

                default: begin
                    w_state_next = ST_HUNT;
                    w_phase_next = '0;
                    w_conf_next  = '0;
                    w_gap_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_HUNT;
            r_sr         <= '0;
            r_phase      <= '0;
            r_conf       <= '0;
            r_gap        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_align_odd  <= 1'b0;
            r_sync_seen  <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sr         <= w_sr_next;
            r_phase      <= w_phase_next;
            r_conf       <= w_conf_next;
            r_gap        <= w_gap_next;
            r_data_out   <= w_data_next;
            r_data_valid <= w_valid_next;
            r_align_odd  <= w_align_next;
            r_sync_seen  <= w_sync_next;
            r_lock_lost  <= w_lost_next;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_locked     = (r_state == ST_LOCKED);
    assign o_align_odd  = r_align_odd;
    assign o_sync_seen  = r_sync_seen;
    assign o_lock_lost  = r_lock_lost;

endmodule
